krnl_partialknn_local_sp_reader: RTL and testbench

KRNL_PARTIALKNN_LOCAL_SP_READER -- requirements
Module: krnl_partialknn_local_sp_reader

---
 rtl/krnl_partialknn_local_sp_reader.sv | 211 +++++++++++++++++++++
 tb/tb_krnl_partialknn_local_sp_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krnl_partialknn_local_sp_reader.sv
// Burst reader: streams a run of consecutive words from a single-port
// memory onto a valid/ready output stream. A small FIFO absorbs the
// memory read latency. Reads are issued only while there is guaranteed
// room for the returning data.
// Optional build macro KRNL_PARTIALKNN_SP_READER_PERF_EN adds the
// perf_stall_cnt output, which counts back-pressure cycles.
module krnl_partialknn_local_sp_reader #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
`ifdef KRNL_PARTIALKNN_SP_READER_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    run_q, run_d;
  logic                    done_q, done_d;
  logic                    ce_q, ce_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        issue_left_q, issue_left_d;
  logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [READ_LATENCY-1:0] lat_sr_q, lat_sr_d;
  logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;

  logic                    accept;
  logic                    accept_burst;
  logic                    accept_empty;
  logic                    capture;
  logic                    pop;
  logic                    last_beat;
  logic                    credit_ok;
  logic                    issue_more;
  logic [CNT_W:0]          credit_used;

  // Handshake decode and read-credit check (a beat leaving this edge frees its slot)
  always_comb begin
    accept       = (state_q == IDLE) && start && run_q;
    accept_burst = accept && (length != '0);
    accept_empty = accept && (length == '0);
    capture      = lat_sr_q[READ_LATENCY-1];
    pop          = m_tvalid && m_tready;
    last_beat    = pop && m_tlast;
    credit_used  = {1'b0, inflight_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
    credit_ok    = credit_used < (CNT_W+1)'(FIFO_DEPTH);
    issue_more   = (state_q == ISSUE) && credit_ok;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: the first read goes out on the accepting edge itself
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_burst) state_d = (length == LEN_W'(1)) ? DRAIN : ISSUE;
      ISSUE:   if (issue_more && (issue_left_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: read issue, latency tracking, FIFO and beat count
  always_comb begin
    run_d        = 1'b1;
    done_d       = 1'b0;
    ce_d         = 1'b0;
    addr_d       = addr_q;
    next_addr_d  = next_addr_q;
    len_d        = len_q;
    issue_left_d = issue_left_q;
    beat_cnt_d   = beat_cnt_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    lat_sr_d[0] = ce_q;
    for (int i = 1; i < READ_LATENCY; i++) lat_sr_d[i] = lat_sr_q[i-1];

    if (accept_burst) begin
      ce_d         = 1'b1;
      addr_d       = base_addr;
      next_addr_d  = base_addr + ADDR_WIDTH'(1);
      len_d        = length;
      issue_left_d = length - LEN_W'(1);
    end else if (issue_more) begin
      ce_d         = 1'b1;
      addr_d       = next_addr_q;
      next_addr_d  = next_addr_q + ADDR_WIDTH'(1);
      issue_left_d = issue_left_q - LEN_W'(1);
    end

    if (accept_empty || last_beat) done_d = 1'b1;

    if (capture) begin
      fifo_d[wr_ptr_q] = mem_q0;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      beat_cnt_d = beat_cnt_q + LEN_W'(1);
    end
    if (accept_burst) beat_cnt_d = '0;

    count_d    = count_q + CNT_W'(capture) - CNT_W'(pop);
    inflight_d = inflight_q + CNT_W'(ce_d) - CNT_W'(capture);
  end

  // Datapath registers, all cleared by reset so a reset drops every pending read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      ce_q         <= 1'b0;
      addr_q       <= '0;
      next_addr_q  <= '0;
      len_q        <= '0;
      issue_left_q <= '0;
      beat_cnt_q   <= '0;
      lat_sr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
    end else begin
      run_q        <= run_d;
      done_q       <= done_d;
      ce_q         <= ce_d;
      addr_q       <= addr_d;
      next_addr_q  <= next_addr_d;
      len_q        <= len_d;
      issue_left_q <= issue_left_d;
      beat_cnt_q   <= beat_cnt_d;
      lat_sr_q     <= lat_sr_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
    end
  end

  // Output decode: stream head is gated so idle data reads as zero
  always_comb begin
    busy         = (state_q != IDLE);
    done         = done_q;
    mem_ce0      = ce_q;
    mem_address0 = addr_q;
    mem_we0      = 1'b0;
    mem_d0       = '0;
    m_tvalid     = (count_q != '0);
    m_tdata      = m_tvalid ? fifo_q[rd_ptr_q] : '0;
    m_tlast      = m_tvalid && (beat_cnt_q == (len_q - LEN_W'(1)));
  end

`ifdef KRNL_PARTIALKNN_SP_READER_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating back-pressure counter, restarted by each accepted start
  always_comb begin
    perf_d = perf_q;
    if (accept) perf_d = '0;
    else if (m_tvalid && !m_tready && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  // Back-pressure counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_krnl_partialknn_local_sp_reader.sv
// Testbench for krnl_partialknn_local_sp_reader: a behavioural memory with
// fixed read latency feeds the reader, a negedge monitor records what the
// reader does, and each burst is compared to the word sequence it must
// produce from the memory contents.
module tb_krnl_partialknn_local_sp_reader;

   localparam int RL    = 2;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [10:0]   base_addr;
   logic [11:0]   length;
   logic          busy;
   logic          done;
   logic [10:0]   mem_address0;
   logic          mem_ce0;
   logic          mem_we0;
   logic [255:0]  mem_d0;
   logic [255:0]  mem_q0;
   logic [255:0]  m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
`ifdef KRNL_PARTIALKNN_SP_READER_PERF_EN
   logic [31:0]   perfCnt;
`endif

   krnl_partialknn_local_sp_reader #(
      .DATA_WIDTH(256), .ADDR_WIDTH(11), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .mem_address0(mem_address0),
      .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef KRNL_PARTIALKNN_SP_READER_PERF_EN
      , .perf_stall_cnt(perfCnt)
`endif
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [255:0] memArr [2048];
   logic [255:0] qPipe  [RL];
   int           cyc = 0;

   // Cycle counter used to express timing relative to the start edge
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: data for an enabled read appears RL cycles later
   always @(posedge clk) begin
      qPipe[0] <= (mem_ce0 === 1'b1) ? memArr[mem_address0] : 'x;
      for (int i = 1; i < RL; i++) qPipe[i] <= qPipe[i-1];
   end
   assign mem_q0 = qPipe[RL-1];

   int testsRun  = 0;
   int failCount = 0;

   // Monitor state for the burst in progress
   bit           monOn = 0;
   int           startCyc, monRel;
   int           beats, ceCnt, doneCnt, doneRel, busyCnt, lastCnt, lastIdx, lastRel;
   int           ceFirst, ceLast, firstValid, maxBuf, weErr;
   bit           prevStall;
   logic [255:0] prevData;
   logic         prevLast;
   logic [10:0]  addrQ [$];
   logic [255:0] dataQ [$];

   task automatic expectEq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] randWord();
      logic [255:0] w;
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
      return w;
   endfunction

   function automatic logic readyFor(input int mode, input int rel, input int lo, input int hi);
      if (mode == 0) return 1'b1;
      if (mode == 1) return !(rel >= lo && rel <= hi);
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic clearMonitor();
      beats = 0; ceCnt = 0; doneCnt = 0; doneRel = -1; busyCnt = 0;
      lastCnt = 0; lastIdx = -1; lastRel = -1; ceFirst = -1; ceLast = -1;
      firstValid = -1; maxBuf = 0; weErr = 0; prevStall = 0;
      prevData = '0; prevLast = 1'b0;
      addrQ.delete(); dataQ.delete();
   endtask

   // Negedge monitor: records reads, beats, done/busy and checks stall stability
   always @(negedge clk) begin
      if (monOn) begin
         monRel = cyc - startCyc;
         if (prevStall) begin
            expectEq("stallValid", m_tvalid, 1'b1);
            expectEq("stallData", m_tdata, prevData);
            expectEq("stallLast", m_tlast, prevLast);
         end
         prevStall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
         prevData  = m_tdata;
         prevLast  = m_tlast;
         if (mem_we0 !== 1'b0 || mem_d0 !== '0) weErr++;
         if (mem_ce0 === 1'b1) begin
            addrQ.push_back(mem_address0);
            ceCnt++;
            if (ceFirst < 0) ceFirst = monRel;
            ceLast = monRel;
         end
         if (ceCnt - beats > maxBuf) maxBuf = ceCnt - beats;
         if (m_tvalid === 1'b1 && firstValid < 0) firstValid = monRel;
         if (busy === 1'b1) busyCnt++;
         if (done === 1'b1) begin doneCnt++; doneRel = monRel; end
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            dataQ.push_back(m_tdata);
            if (m_tlast === 1'b1) begin lastCnt++; lastIdx = beats; lastRel = monRel; end
            beats++;
         end
      end
   end

   task automatic checkReset(input string tag);
      expectEq({tag, ".busy"}, busy, 1'b0);
      expectEq({tag, ".done"}, done, 1'b0);
      expectEq({tag, ".ce"}, mem_ce0, 1'b0);
      expectEq({tag, ".we"}, mem_we0, 1'b0);
      expectEq({tag, ".tvalid"}, m_tvalid, 1'b0);
      expectEq({tag, ".tlast"}, m_tlast, 1'b0);
      expectEq({tag, ".addr"}, mem_address0, 11'h0);
      expectEq({tag, ".d0"}, mem_d0, 256'h0);
      expectEq({tag, ".tdata"}, m_tdata, 256'h0);
   endtask

   // Run one burst; mode 0 = ready high, 1 = ready low in [lo,hi], 2 = random ready.
   // With chain set, the next burst's start is driven in the done cycle.
   task automatic applyStimulus(input logic [10:0] b, input logic [11:0] n, input int mode,
                                input int lo, input int hi, input bit preStarted,
                                input bit chain, input logic [10:0] nb, input logic [11:0] nn);
      int budget;
      bit gotDone;
      if (!preStarted) begin base_addr = b; length = n; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      clearMonitor();
      startCyc = cyc - 1;
      monOn = 1;
      budget = 8 * int'(n) + 60;
      gotDone = 0;
      for (int k = 0; k < budget; k++) begin
         m_tready = readyFor(mode, cyc - startCyc, lo, hi);
         if (done === 1'b1) begin
            gotDone = 1;
            if (chain) begin base_addr = nb; length = nn; start = 1'b1; end
            break;
         end
         @(posedge clk); #1;
      end
      expectEq("doneSeen", gotDone, 1'b1);
      @(negedge clk); #1;
      if (!chain) begin
         m_tready = 1'b1;
         repeat (3) @(negedge clk);
         #1;
      end
   endtask

   // Compare the recorded burst against the word sequence the memory holds
   task automatic checkOutput(input string tag, input logic [10:0] b, input logic [11:0] n, input bit timing);
      logic [10:0] a;
      int nInt;
      nInt = int'(n);
      expectEq({tag, ".beats"}, beats, nInt);
      expectEq({tag, ".reads"}, ceCnt, nInt);
      for (int i = 0; i < nInt; i++) begin
         a = 11'(int'(b) + i);
         if (i < addrQ.size()) expectEq($sformatf("%s.addr[%0d]", tag, i), addrQ[i], a);
         if (i < dataQ.size()) expectEq($sformatf("%s.data[%0d]", tag, i), dataQ[i], memArr[a]);
      end
      expectEq({tag, ".lastCount"}, lastCnt, (nInt == 0) ? 0 : 1);
      if (nInt > 0) expectEq({tag, ".lastIndex"}, lastIdx, nInt - 1);
      expectEq({tag, ".doneCount"}, doneCnt, 1);
      expectEq({tag, ".bufferedWithinDepth"}, (maxBuf <= DEPTH), 1'b1);
      expectEq({tag, ".writeSide"}, weErr, 0);
      if (timing) begin
         if (nInt == 0) begin
            expectEq({tag, ".doneCycle"}, doneRel, 1);
            expectEq({tag, ".busyCycles"}, busyCnt, 0);
            expectEq({tag, ".firstValid"}, firstValid, -1);
         end else begin
            expectEq({tag, ".ceFirst"}, ceFirst, 1);
            expectEq({tag, ".ceLast"}, ceLast, nInt);
            expectEq({tag, ".firstValid"}, firstValid, RL + 2);
            expectEq({tag, ".lastCycle"}, lastRel, nInt + RL + 1);
            expectEq({tag, ".doneCycle"}, doneRel, nInt + RL + 2);
            expectEq({tag, ".busyCycles"}, busyCnt, nInt + RL + 1);
         end
      end
   endtask

   logic [10:0] bVal, bNext;
   logic [11:0] nVal;

   initial begin
      for (int i = 0; i < 2048; i++) memArr[i] = randWord();
      reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_tready = 1'b1;
      clearMonitor();

      repeat (3) @(posedge clk);
      #1 checkReset("reset");

      // Start on the first edge after reset release must be ignored
      @(negedge clk);
      reset_n = 1'b1; base_addr = 11'd5; length = 12'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clearMonitor(); startCyc = cyc - 1; monOn = 1;
      repeat (6) @(negedge clk);
      #1;
      expectEq("syncStart.busy", busyCnt, 0);
      expectEq("syncStart.reads", ceCnt, 0);
      expectEq("syncStart.done", doneCnt, 0);

      applyStimulus(11'h010, 12'd8, 0, 0, 0, 0, 0, '0, '0);
      checkOutput("basic", 11'h010, 12'd8, 1);

      applyStimulus(11'h7FE, 12'd4, 0, 0, 0, 0, 0, '0, '0);
      checkOutput("wrap", 11'h7FE, 12'd4, 1);

      bVal = 11'($urandom_range(0, 2047));
      applyStimulus(bVal, 12'd16, 1, 5, 14, 0, 0, '0, '0);
      checkOutput("stall", bVal, 12'd16, 0);
`ifdef KRNL_PARTIALKNN_SP_READER_PERF_EN
      expectEq("stall.perfCount", perfCnt, 32'd10);
`endif

      bVal = 11'($urandom_range(0, 2047));
      applyStimulus(bVal, 12'd0, 0, 0, 0, 0, 0, '0, '0);
      checkOutput("zeroLen", bVal, 12'd0, 1);

      for (int t = 0; t < 8; t++) begin
         bVal = 11'($urandom_range(0, 2047));
         nVal = 12'($urandom_range(1, 40));
         applyStimulus(bVal, nVal, 2, 0, 0, 0, 0, '0, '0);
         checkOutput($sformatf("rand%0d", t), bVal, nVal, 0);
      end

      // Reset in the middle of a 32-word burst
      monOn = 0;
      bVal = 11'($urandom_range(0, 2047));
      base_addr = bVal; length = 12'd32; start = 1'b1; m_tready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; startCyc = cyc - 1;
      while (cyc - startCyc < 6) begin @(posedge clk); #1; end
      #2 reset_n = 1'b0;
      #1 checkReset("midReset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      clearMonitor(); startCyc = cyc - 1; monOn = 1;
      repeat (20) @(negedge clk);
      #1;
      expectEq("afterReset.beats", beats, 0);
      expectEq("afterReset.done", doneCnt, 0);
      expectEq("afterReset.reads", ceCnt, 0);
      applyStimulus(11'h000, 12'd2, 0, 0, 0, 0, 0, '0, '0);
      checkOutput("postReset", 11'h000, 12'd2, 1);

      // New start in the done cycle, full 2048-word burst
      bVal  = 11'($urandom_range(0, 2047));
      bNext = 11'($urandom_range(0, 2047));
      applyStimulus(bVal, 12'd5, 0, 0, 0, 0, 1, bNext, 12'd2048);
      checkOutput("chainA", bVal, 12'd5, 1);
      applyStimulus(bNext, 12'd2048, 0, 0, 0, 1, 0, '0, '0);
      checkOutput("chainB", bNext, 12'd2048, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
